// File: rtl/translator_div_pkg.sv
// translator_div_pkg: shared widths and FSM encoding for the translator divider.
package translator_div_pkg;
  localparam int DIVIDEND_WIDTH = 22;
  localparam int DIVISOR_WIDTH  = 10;
  localparam int QUOTIENT_WIDTH = 12;
  localparam int COUNT_WIDTH    = $clog2(QUOTIENT_WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/translator_udiv_step.sv
// translator_udiv_step: one combinational restoring-division step.
module translator_udiv_step
  import translator_div_pkg::*;
(
  input  logic [DIVISOR_WIDTH-1:0] pr,
  input  logic                     bit_in,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH-1:0] pr_next,
  output logic                     q_bit
);
  logic [DIVISOR_WIDTH:0] t;
  // The difference is always below the divisor, so the low bits of T suffice for the subtract.
  always_comb begin
    t       = {pr, bit_in};
    q_bit   = t >= {1'b0, divisor};
    pr_next = q_bit ? t[DIVISOR_WIDTH-1:0] - divisor : t[DIVISOR_WIDTH-1:0];
  end
endmodule

// File: rtl/translator_udiv_seq.sv
// translator_udiv_seq: 22/10 unsigned restoring divider, one quotient bit per cycle.
module translator_udiv_seq
  import translator_div_pkg::*;
(
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_start,
  output logic                      ap_ready,
  output logic                      ap_idle,
  output logic                      ap_done,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic [QUOTIENT_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      div_by_zero,
  output logic                      ovf
);
  state_t                    state, state_next;
  logic [COUNT_WIDTH-1:0]    count;
  logic [DIVISOR_WIDTH-1:0]  pr, pr_next, divisor;
  logic [QUOTIENT_WIDTH-1:0] dvd_lo, q_acc, q_full;
  logic                      dbz, ov, q_bit, last;

  translator_udiv_step u_step (
    .pr      (pr),
    .bit_in  (dvd_lo[COUNT_WIDTH'(QUOTIENT_WIDTH-1) - count]),
    .divisor (divisor),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    ap_idle    = state == IDLE;
    ap_ready   = ap_idle && ap_start;
    ap_done    = state == DONE;
    last       = count == COUNT_WIDTH'(QUOTIENT_WIDTH-1);
    q_full     = {q_acc[QUOTIENT_WIDTH-2:0], q_bit};
    state_next = ap_ready                 ? CALC :
                 (state == CALC && last)  ? DONE :
                 (state == DONE)          ? IDLE : state;
  end

  // Special cases still iterate so latency stays fixed; their results override at the end.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count       <= '0;
      pr          <= '0;
      divisor     <= '0;
      dvd_lo      <= '0;
      q_acc       <= '0;
      dbz         <= 1'b0;
      ov          <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else if (ap_ready) begin
      count   <= '0;
      pr      <= din0[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH];
      divisor <= din1;
      dvd_lo  <= din0[QUOTIENT_WIDTH-1:0];
      q_acc   <= '0;
      dbz     <= din1 == '0;
      ov      <= din1 != '0 && din0[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH] >= din1;
    end else if (state == CALC) begin
      count <= count + 1'b1;
      pr    <= pr_next;
      q_acc <= q_full;
      if (last) begin
        quot        <= (dbz || ov) ? '1 : q_full;
        rem         <= dbz ? dvd_lo[DIVISOR_WIDTH-1:0] : ov ? '0 : pr_next;
        div_by_zero <= dbz;
        ovf         <= ov;
      end
    end
  end
endmodule

// File: tb/tb_translator_udiv_seq.sv
// tb_translator_udiv_seq: directed table, handshake sequences and random ops against a division model.
module tb_translator_udiv_seq;
  logic        ap_clk = 0, ap_rst_n = 0, ap_start = 0;
  logic        ap_ready, ap_idle, ap_done, div_by_zero, ovf;
  logic [21:0] din0 = '0;
  logic [9:0]  din1 = '0, rem;
  logic [11:0] quot;
  int errors = 0, checks = 0;

  typedef struct {
    logic [21:0] a;
    logic [9:0]  b;
    logic [11:0] q;
    logic [9:0]  r;
    logic        dz;
    logic        ov;
  } vec_t;
  vec_t vecs[10];

  translator_udiv_seq dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .ap_done(ap_done), .din0(din0), .din1(din1), .quot(quot),
    .rem(rem), .div_by_zero(div_by_zero), .ovf(ovf)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [21:0] a, input logic [9:0] b, input logic [11:0] eq,
                       input logic [9:0] er, input logic edz, input logic eov, input string tag);
    int n = 0;
    @(negedge ap_clk);
    while (!ap_idle && n < 20) begin @(negedge ap_clk); n++; end
    din0 = a; din1 = b; ap_start = 1; #1;
    chk({tag, " ready"}, ap_ready, 1);
    @(posedge ap_clk); #1;
    ap_start = 0; din0 = '0; din1 = '0; n = 1;
    while (!ap_done && n < 30) begin @(posedge ap_clk); #1; n++; end
    chk({tag, " latency"}, n, 13);
    chk({tag, " idle_in_done"}, ap_idle, 0);
    chk({tag, " quot"}, quot, eq);
    chk({tag, " rem"}, rem, er);
    chk({tag, " dbz"}, div_by_zero, edz);
    chk({tag, " ovf"}, ovf, eov);
  endtask

  initial begin
    vecs[0] = '{1000000, 999, 1001, 1, 0, 0};
    vecs[1] = '{4190207, 1023, 4095, 1022, 0, 0};
    vecs[2] = '{4190208, 1023, 4095, 0, 0, 1};
    vecs[3] = '{12345, 0, 4095, 57, 1, 0};
    vecs[4] = '{100, 7, 14, 2, 0, 0};
    vecs[5] = '{0, 5, 0, 0, 0, 0};
    vecs[6] = '{4194303, 0, 4095, 1023, 1, 0};
    vecs[7] = '{4095, 1, 4095, 0, 0, 0};
    vecs[8] = '{4096, 1, 4095, 0, 0, 1};
    vecs[9] = '{1023, 1023, 1, 0, 0, 0};

    #12;
    chk("reset idle", ap_idle, 1);
    chk("reset done", ap_done, 0);
    chk("reset ready", ap_ready, 0);
    chk("reset quot", quot, 0);
    chk("reset rem", rem, 0);
    chk("reset flags", {div_by_zero, ovf}, 0);
    @(negedge ap_clk); ap_rst_n = 1;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov, $sformatf("vec%0d", i));

    // Back-to-back with ap_start held high.
    @(negedge ap_clk);
    while (!ap_idle) @(negedge ap_clk);
    din0 = 100; din1 = 7; ap_start = 1;
    for (int c = 0; c < 28; c++) begin
      #1;
      chk($sformatf("b2b ready c%0d", c), ap_ready, c == 0 || c == 14);
      chk($sformatf("b2b done c%0d", c), ap_done, c == 13 || c == 27);
      if (c == 13) begin
        chk("b2b q1", quot, 14); chk("b2b r1", rem, 2); chk("b2b f1", {div_by_zero, ovf}, 0);
      end
      if (c == 20) chk("b2b hold q1", quot, 14);
      if (c == 27) begin
        chk("b2b q2", quot, 4095); chk("b2b r2", rem, 0); chk("b2b f2", {div_by_zero, ovf}, 2'b01);
      end
      @(negedge ap_clk);
      if (c == 0) begin din0 = 4194303; din1 = 1023; end
    end
    ap_start = 0;

    // Abort mid-operation with reset.
    do_op(1000000, 999, 1001, 1, 0, 0, "pre_reset");
    @(negedge ap_clk);
    while (!ap_idle) @(negedge ap_clk);
    din0 = 1000000; din1 = 999; ap_start = 1;
    @(negedge ap_clk); ap_start = 0;
    repeat (4) @(negedge ap_clk);
    ap_rst_n = 0; #1;
    chk("abort idle", ap_idle, 1);
    chk("abort quot", quot, 0);
    chk("abort rem", rem, 0);
    chk("abort flags", {div_by_zero, ovf}, 0);
    chk("abort done", ap_done, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1;
    for (int c = 0; c < 16; c++) begin
      @(posedge ap_clk); #1;
      chk("abort no done", ap_done, 0);
    end
    do_op(50, 3, 16, 2, 0, 0, "post_reset");

    for (int i = 0; i < 1000; i++) begin
      logic [21:0] a;
      logic [9:0]  b, er;
      logic [11:0] eq;
      logic        edz, eov;
      int unsigned sel;
      sel = $urandom_range(0, 3);
      b = sel == 0 ? 10'd0 : sel == 1 ? 10'd1 : sel == 2 ? 10'd1023 : 10'($urandom_range(0, 1023));
      a = 22'($urandom_range(0, 22'h3FFFFF) >> $urandom_range(0, 12));
      edz = b == 0;
      eov = !edz && ({10'd0, a} >= ({22'd0, b} << 12));
      eq = (edz || eov) ? 12'hFFF : 12'(a / b);
      er = edz ? a[9:0] : eov ? 10'd0 : 10'(a % b);
      do_op(a, b, eq, er, edz, eov, $sformatf("rnd%0d a=%0d b=%0d", i, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
